// File: rtl/pac_wb_sched.sv
// Purpose: streams counter-buffer lines to host memory as single-beat AXI writes, optionally zeroing each line after it is read.
// Latency: 3 cycles per line (read, capture, send) with AW/W ready; done follows the last B response by 1-2 cycles.
// Backpressure: AW/W hold valid and payload until their own handshake; reads stall while MAX_OUTST writes await B.
module pac_wb_sched #(
  parameter int BUF_AW    = 10,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear_en,
  input  logic [63:0]         base_addr,
  input  logic [BUF_AW:0]     line_cnt,
  output logic                buf_rden,
  output logic [BUF_AW-1:0]   buf_rdaddress,
  input  logic [DATA_W-1:0]   buf_rdata,
  output logic                buf_wren,
  output logic [BUF_AW-1:0]   buf_wraddress,
  output logic [DATA_W-1:0]   buf_wdata,
  output logic                awvalid,
  input  logic                awready,
  output logic [63:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0]     MAX_O   = OW'(MAX_OUTST);
  localparam logic [OW-1:0]     ONE_O   = OW'(1);
  localparam logic [BUF_AW-1:0] ONE_IDX = BUF_AW'(1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_SEND, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nx;
  logic [BUF_AW-1:0]  idx, last_idx;
  logic [63:6]        base_q;
  logic               clr_q;
  logic [OW-1:0]      outst;
  logic               aw_done, w_done;
  logic               aw_fire, w_fire, b_fire, pair_fire, start_acc, is_last;
  logic               unused_bits;

  // Low address bits are forced to line alignment and the count MSB only
  // matters through wrap-around of (line_cnt - 1), so neither is read.
  assign unused_bits = ^{line_cnt[BUF_AW], base_addr[5:0]};

  assign aw_fire   = awvalid & awready;
  assign w_fire    = wvalid & wready;
  assign b_fire    = bvalid & bready;
  assign start_acc = (state == S_IDLE) & start;
  assign is_last   = (idx == last_idx);
  assign pair_fire = (state == S_SEND) & (aw_done | aw_fire) & (w_done | w_fire);

  assign buf_rdaddress = idx;
  assign buf_wraddress = idx;
  assign buf_wdata     = '0;
  assign awaddr        = {base_q, 6'b0} + {{(58-BUF_AW){1'b0}}, idx, 6'b0};
  assign awlen         = '0;
  assign awsize        = 3'b110;
  assign awburst       = 2'b01;
  assign wstrb         = '1;
  assign wlast         = 1'b1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nx = state;
    buf_rden = 1'b0;
    buf_wren = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_RD;
      end
      S_RD: begin
        busy = 1'b1;
        if (outst != MAX_O) begin
          buf_rden = 1'b1;
          state_nx = S_LAT;
        end
      end
      S_LAT: begin
        busy     = 1'b1;
        buf_wren = clr_q;
        state_nx = S_SEND;
      end
      S_SEND: begin
        busy = 1'b1;
        if (pair_fire) state_nx = is_last ? S_DRAIN : S_RD;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (outst == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Transfer parameters are latched once per accepted start; idx walks the lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      last_idx <= '0;
      clr_q    <= 1'b0;
      idx      <= '0;
    end else if (start_acc) begin
      base_q   <= base_addr[63:6];
      last_idx <= line_cnt[BUF_AW-1:0] - ONE_IDX;
      clr_q    <= clear_en;
      idx      <= '0;
    end else if (pair_fire && !is_last) begin
      idx <= idx + ONE_IDX;
    end
  end

  // AW and W are launched together and retire independently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      wdata   <= '0;
    end else if (state == S_LAT) begin
      wdata   <= buf_rdata;
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_fire) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_fire) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
    end
  end

  // Outstanding-write count; a B response with nothing outstanding is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outst <= '0;
    end else begin
      case ({pair_fire, b_fire && (outst != '0)})
        2'b10:   outst <= outst + ONE_O;
        2'b01:   outst <= outst - ONE_O;
        default: outst <= outst;
      endcase
    end
  end

  // Sticky error on any non-OKAY response, cleared by the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err <= 1'b0;
    else if (start_acc)                 err <= 1'b0;
    else if (b_fire && bresp != 2'b00)  err <= 1'b1;
  end

  // bready is held low only while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bready <= 1'b0;
    else       bready <= 1'b1;
  end

endmodule
